que_dispatch_ctrl: RTL

QUE_DISPATCH_CTRL -- requirements
Module: que_dispatch_ctrl

---
 rtl/que_dispatch_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/que_dispatch_ctrl.sv
// Queue dispatch controller: arbitrator snapshot, packet read, word stream.
// Optional statistics counters are built when QUE_DISPATCH_STAT_EN is defined.
module que_dispatch_ctrl #(
    parameter int PORTNUM = 16,
    parameter int LENW    = 10
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [$clog2(PORTNUM)-1:0] i_port,
    input  logic                       i_port_vld,
    input  logic                       i_empty,
    output logic                       o_update,
    output logic [$clog2(PORTNUM)-1:0] o_clr_port,
    output logic                       o_clr_vld,
    output logic                       o_rd_req,
    output logic [$clog2(PORTNUM)-1:0] o_rd_port,
    input  logic                       i_rd_ack,
    input  logic [LENW-1:0]            i_rd_len,
    input  logic                       i_out_rdy,
    output logic                       o_rd_en,
    output logic                       o_rd_last,
`ifdef QUE_DISPATCH_STAT_EN
    output logic [31:0]                o_pkt_cnt,
    output logic [31:0]                o_word_cnt,
`endif
    output logic                       o_busy
);

    localparam int PW = $clog2(PORTNUM);
    localparam logic [LENW-1:0] ONE = {{(LENW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        UPD,
        SETTLE,
        WAIT,
        REQ,
        XFER,
        CLR
    } state_t;

    state_t          state;
    logic [PW-1:0]   port_q;
    logic [LENW-1:0] len_q;
    logic [LENW-1:0] cnt_q;
    logic            last_word;

    assign o_rd_en    = (state == XFER) && i_out_rdy;
    assign last_word  = (cnt_q == len_q - ONE);
    assign o_rd_last  = o_rd_en && last_word;
    assign o_rd_port  = port_q;
    assign o_clr_port = port_q;

    // Dispatch sequencer; pulse and level outputs are registered with the state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            o_update  <= 1'b0;
            o_clr_vld <= 1'b0;
            o_rd_req  <= 1'b0;
            o_busy    <= 1'b0;
            port_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
        end else begin
            o_update  <= 1'b0;
            o_clr_vld <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_en) begin
                        state    <= UPD;
                        o_update <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end
                UPD: begin
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (i_port_vld) begin
                        port_q   <= i_port;
                        state    <= REQ;
                        o_rd_req <= 1'b1;
                    end else if (i_empty) begin
                        if (i_en) begin
                            state    <= UPD;
                            o_update <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (i_rd_ack) begin
                        len_q    <= i_rd_len;
                        cnt_q    <= '0;
                        o_rd_req <= 1'b0;
                        if (i_rd_len == '0) begin
                            state     <= CLR;
                            o_clr_vld <= 1'b1;
                        end else begin
                            state <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (o_rd_en) begin
                        cnt_q <= cnt_q + ONE;
                        if (last_word) begin
                            state     <= CLR;
                            o_clr_vld <= 1'b1;
                        end
                    end
                end
                CLR: begin
                    state <= SETTLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef QUE_DISPATCH_STAT_EN
    // Saturating packet and word statistics.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_pkt_cnt  <= '0;
            o_word_cnt <= '0;
        end else begin
            if (o_clr_vld && (o_pkt_cnt != '1)) begin
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
            end
            if (o_rd_en && (o_word_cnt != '1)) begin
                o_word_cnt <= o_word_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
